exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception and return sequencer that drives the write port of the MSR register and consumes its read port. It takes machine-check, external-interrupt and system-call events, saves the resume PC and the current MSR into SRR0/SRR1, and writes the new MSR image. It then redirects fetch to the architected vector. It also executes `rfi` by restoring MSR from SRR1 and redirecting fetch to SRR0. It sits between decode/fetch and the MSR register; ordinary `mtmsr` writes from the core pass through it.

## Interface
Parameters:
- `MSR_WIDTH`, 32: MSR width; bit numbering [0:31], big-endian.
- `VEC_MCHK`, 32'h0000_0200: machine-check vector.
- `VEC_EXT`, 32'h0000_0500: external-interrupt vector.
- `VEC_SC`, 32'h0000_0C00: system-call vector.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mchk` in 1: machine-check request, level.
- `ext_irq` in 1: external interrupt, level; held by the source until serviced.
- `sc_req` in 1: system call decoded this cycle; sampled only in IDLE.
- `rfi_req` in 1: `rfi` decoded this cycle; sampled only in IDLE.
- `pc_cur` in [0:31]: address of the instruction to resume.
- `core_msr_wr` in 1: core `mtmsr` write strobe.
- `core_msr_wd` in [0:31]: core `mtmsr` data.
- `msr_rd` in [0:31]: current MSR value.
- `msr_wr` out 1: MSR write strobe.
- `msr_wd` out [0:31]: MSR write data.
- `srr0` out [0:31]: save/restore register 0.
- `srr1` out [0:31]: save/restore register 1.
- `redir_vld` out 1: one-cycle fetch-redirect strobe.
- `redir_pc` out [0:31]: redirect target.
- `busy` out 1: core stall request.
- `checkstop` out 1: processor halted.

## Operation
- States: IDLE, SAVE, VECT, RFI, RET, STOP.
- Event priority in IDLE, evaluated against the current `msr_rd`:
  - mchk with ME=1 goes to SAVE with cause MCHK.
  - mchk with ME=0 goes to STOP.
  - ext_irq with EE=1 goes to SAVE with cause EXT.
  - sc_req goes to SAVE with cause SC.
  - rfi_req goes to RFI.
  - Otherwise remain in IDLE.
- The cause is latched in a 2-bit register on entry to SAVE.
- ext_irq with EE=0 is ignored and stays pending; it is not latched.
- IDLE:
  - msr_wr = core_msr_wr and msr_wd = core_msr_wd; the core write is forwarded even in the cycle an event is accepted.
  - busy = 0.
- SAVE:
  - srr0 <= pc_cur and srr1 <= msr_rd at the cycle-end edge.
  - msr_wr = 1. msr_wd = msr_rd with bit 16 (EE) forced to 0, bit 19 (ME) forced to 0 when cause is MCHK (else kept), and bit 31 (LE) kept. All other bits are 0.
  - Next state: VECT.
- VECT:
  - redir_vld = 1 and redir_pc = the vector for the cause.
  - Next state: IDLE.
- RFI:
  - msr_wr = 1 and msr_wd = srr1 masked to bits 16, 19 and 31.
  - Next state: RET.
- RET:
  - redir_vld = 1 and redir_pc = srr0.
  - Next state: IDLE.
- STOP:
  - checkstop = 1, busy = 1, msr_wr = 0.
  - Absorbing; only rst leaves it.
- busy = 1 in every state except IDLE.
- core_msr_wr is ignored outside IDLE.
- sc_req and rfi_req outside IDLE are dropped; the core is stalled, so none arrive legally.

## Timing
- Reset: state = IDLE; srr0 = srr1 = 0; latched cause = 0; redir_vld = 0; busy = 0; checkstop = 0; msr_wr = 0 (msr_wd = core_msr_wd = don't-care).
- Reset mid-sequence returns to IDLE at the next edge with no redirect issued.
- Exception accepted at edge N:
  - SAVE occupies cycle N..N+1, with the MSR write and SRR capture at edge N+1.
  - VECT occupies N+1..N+2, during which redir_vld is high.
  - IDLE is re-entered at N+2.
  - Total latency from acceptance to redirect is 2 cycles; busy is high for 2 cycles.
- rfi: the same 2-cycle shape (RFI then RET). The restored MSR is visible on msr_rd in RET.
- rfi_req and an enabled interrupt in the same cycle: the interrupt wins, srr0 = pc_cur (the rfi address), and the rfi re-executes on return.
- mtmsr and an event in the same IDLE cycle: the write is forwarded, so SAVE captures the post-mtmsr MSR into srr1.
- Back-to-back: after RET restores EE=1 with ext_irq still high, the interrupt is accepted in the first IDLE cycle (no gap cycle required).
- mchk arriving during SAVE/VECT/RFI/RET is not sampled until IDLE; it is held as a level.

## Test plan
- Reset → all outputs at their reset values; sc_req at pc_cur=0x100 with msr_rd=0x0000_8001 (EE=1, LE=1) → in SAVE, msr_wr=1 and msr_wd=0x0000_0001. Next cycle: srr0=0x100, srr1=0x0000_8001, redir_vld=1, redir_pc=0xC00. Then IDLE.
- ext_irq=1 with EE=0 → no action, busy=0. Then mtmsr 0x0000_8000 → next IDLE cycle accepts EXT, redir_pc=0x500 two cycles later, srr1=0x0000_8000.
- rfi with srr1=0xFFFF_FFFF, srr0=0x2000 → msr_wd=0x0000_9001, then redir_pc=0x2000; ext_irq held high → EXT accepted on the immediately following IDLE cycle.
- mchk with ME=1 (msr_rd=0x0000_9000) → msr_wd=0x0000_0000, redir_pc=0x200. A second mchk after that sequence, with ME=0 → STOP: checkstop=1 and busy=1 stay asserted until rst, after which checkstop=0.
- Simultaneous rfi_req and ext_irq (EE=1) at pc_cur=0x300 → EXT taken, srr0=0x300. Also assert rst during VECT → IDLE with redir_vld=0.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception/return sequencer: saves PC and MSR into SRR0/SRR1, rewrites the MSR,
// redirects fetch to the architected vector, and runs rfi from the saved state.
module exc_ctrl #(
    parameter int          MSR_WIDTH = 32,
    parameter logic [0:31] VEC_MCHK  = 32'h0000_0200,
    parameter logic [0:31] VEC_EXT   = 32'h0000_0500,
    parameter logic [0:31] VEC_SC    = 32'h0000_0C00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mchk,
    input  logic                 ext_irq,
    input  logic                 sc_req,
    input  logic                 rfi_req,
    input  logic [0:31]          pc_cur,
    input  logic                 core_msr_wr,
    input  logic [0:MSR_WIDTH-1] core_msr_wd,
    input  logic [0:MSR_WIDTH-1] msr_rd,
    output logic                 msr_wr,
    output logic [0:MSR_WIDTH-1] msr_wd,
    output logic [0:31]          srr0,
    output logic [0:MSR_WIDTH-1] srr1,
    output logic                 redir_vld,
    output logic [0:31]          redir_pc,
    output logic                 busy,
    output logic                 checkstop,
    output logic [2:0]           state_dbg
);

    localparam int EE = 16;
    localparam int ME = 19;
    localparam int LE = 31;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SAVE = 3'd1,
        VECT = 3'd2,
        RFI  = 3'd3,
        RET  = 3'd4,
        STOP = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_MCHK = 2'd1,
        CAUSE_EXT  = 2'd2,
        CAUSE_SC   = 2'd3
    } cause_e;

    state_e                 state;
    cause_e                 cause;
    logic [0:MSR_WIDTH-1]   save_img;
    logic [0:MSR_WIDTH-1]   rfi_img;
    logic [0:31]            vec_pc;

    assign state_dbg = state;

    // MSR image written on exception entry: EE off, ME off only for machine check.
    always_comb begin
        save_img     = '0;
        save_img[ME] = (cause == CAUSE_MCHK) ? 1'b0 : msr_rd[ME];
        save_img[LE] = msr_rd[LE];
    end

    always_comb begin
        rfi_img     = '0;
        rfi_img[EE] = srr1[EE];
        rfi_img[ME] = srr1[ME];
        rfi_img[LE] = srr1[LE];
    end

    always_comb begin
        case (cause)
            CAUSE_MCHK: vec_pc = VEC_MCHK;
            CAUSE_EXT:  vec_pc = VEC_EXT;
            CAUSE_SC:   vec_pc = VEC_SC;
            default:    vec_pc = '0;
        endcase
    end

    // MSR write port: core mtmsr passes through only while idle.
    always_comb begin
        msr_wr = 1'b0;
        msr_wd = core_msr_wd;
        case (state)
            IDLE: msr_wr = core_msr_wr & ~rst;
            SAVE: begin
                msr_wr = 1'b1;
                msr_wd = save_img;
            end
            RFI: begin
                msr_wr = 1'b1;
                msr_wd = rfi_img;
            end
            default: msr_wr = 1'b0;
        endcase
    end

    // redir_vld is a single-cycle strobe with redir_pc valid alongside it;
    // fetch has no back-pressure, so there is no ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cause     <= CAUSE_NONE;
            srr0      <= '0;
            srr1      <= '0;
            redir_vld <= 1'b0;
            redir_pc  <= '0;
            busy      <= 1'b0;
            checkstop <= 1'b0;
        end else begin
            redir_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (mchk && msr_rd[ME]) begin
                        state <= SAVE;
                        cause <= CAUSE_MCHK;
                        busy  <= 1'b1;
                    end else if (mchk) begin
                        state     <= STOP;
                        busy      <= 1'b1;
                        checkstop <= 1'b1;
                    end else if (ext_irq && msr_rd[EE]) begin
                        state <= SAVE;
                        cause <= CAUSE_EXT;
                        busy  <= 1'b1;
                    end else if (sc_req) begin
                        state <= SAVE;
                        cause <= CAUSE_SC;
                        busy  <= 1'b1;
                    end else if (rfi_req) begin
                        state <= RFI;
                        busy  <= 1'b1;
                    end
                end
                SAVE: begin
                    srr0      <= pc_cur;
                    srr1      <= msr_rd;
                    redir_vld <= 1'b1;
                    redir_pc  <= vec_pc;
                    state     <= VECT;
                end
                VECT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                RFI: begin
                    redir_vld <= 1'b1;
                    redir_pc  <= srr0;
                    state     <= RET;
                end
                RET: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                STOP: begin
                    state     <= STOP;
                    busy      <= 1'b1;
                    checkstop <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed steps plus random events, checked against a
// rule-level model of MSR/SRR behaviour with an MSR register kept in the bench.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mchk, ext_irq, sc_req, rfi_req;
    logic [0:31] pc_cur;
    logic        core_msr_wr;
    logic [0:31] core_msr_wd;
    logic [0:31] msr_rd;
    logic        msr_wr;
    logic [0:31] msr_wd;
    logic [0:31] srr0, srr1;
    logic        redir_vld;
    logic [0:31] redir_pc;
    logic        busy, checkstop;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_msr, m_srr0, m_srr1;

    exc_ctrl dut (
        .clk(clk), .rst(rst), .mchk(mchk), .ext_irq(ext_irq), .sc_req(sc_req),
        .rfi_req(rfi_req), .pc_cur(pc_cur), .core_msr_wr(core_msr_wr),
        .core_msr_wd(core_msr_wd), .msr_rd(msr_rd), .msr_wr(msr_wr), .msr_wd(msr_wd),
        .srr0(srr0), .srr1(srr1), .redir_vld(redir_vld), .redir_pc(redir_pc),
        .busy(busy), .checkstop(checkstop), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // The MSR register this block writes into.
    logic [0:31] msr_q;
    always @(posedge clk) begin
        if (rst) msr_q <= '0;
        else if (msr_wr) msr_q <= msr_wd;
    end
    assign msr_rd = msr_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        m_msr  = 0;
        m_srr0 = 0;
        m_srr1 = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_redir", redir_vld, 0);
        chk("rst_chkstop", checkstop, 0);
        chk("rst_msr_wr", msr_wr, 0);
        chk("rst_srr0", srr0, 0);
        chk("rst_srr1", srr1, 0);
    endtask

    // rst_at: 0 none, 1 reset during SAVE, 2 reset during VECT
    task automatic do_event(input bit mc, input bit ex, input bit sc, input bit rf,
                            input logic [31:0] pc, input bit wr, input logic [31:0] wd,
                            input int rst_at);
        int kind;  // 0 none, 1 mchk, 2 ext, 3 sc, 4 rfi, 5 stop
        logic [31:0] new_msr, vec;
        mchk = mc; ext_irq = ex; sc_req = sc; rfi_req = rf;
        pc_cur = pc; core_msr_wr = wr; core_msr_wd = wd;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_fwd_wr", msr_wr, wr);
        if (wr) chk("idle_fwd_wd", msr_wd, wd);
        if (mc && (m_msr & 32'h1000) != 0)      kind = 1;
        else if (mc)                            kind = 5;
        else if (ex && (m_msr & 32'h8000) != 0) kind = 2;
        else if (sc)                            kind = 3;
        else if (rf)                            kind = 4;
        else                                    kind = 0;
        tick();
        if (wr) m_msr = wd;
        mchk = 1'b0; sc_req = 1'b0; rfi_req = 1'b0; core_msr_wr = 1'b0;
        if (kind == 2) ext_irq = 1'b0;
        #1;
        if (kind >= 1 && kind <= 3) begin
            new_msr = m_msr & ((kind == 1) ? 32'h0000_0001 : 32'h0000_1001);
            vec = (kind == 1) ? 32'h200 : (kind == 2) ? 32'h500 : 32'hC00;
            chk("save_busy", busy, 1);
            chk("save_wr", msr_wr, 1);
            chk("save_wd", msr_wd, new_msr);
            chk("save_redir", redir_vld, 0);
            if (rst_at == 1) rst = 1'b1;
            tick();
            if (rst_at == 1) begin
                rst = 1'b0; m_msr = 0; m_srr0 = 0; m_srr1 = 0;
                #1;
                chk("rst_save_redir", redir_vld, 0);
                chk("rst_save_busy", busy, 0);
                chk("rst_save_srr0", srr0, 0);
                return;
            end
            m_srr0 = pc; m_srr1 = m_msr; m_msr = new_msr;
            core_msr_wr = 1'b1; core_msr_wd = $urandom;
            #1;
            chk("vect_redir", redir_vld, 1);
            chk("vect_pc", redir_pc, vec);
            chk("vect_srr0", srr0, m_srr0);
            chk("vect_srr1", srr1, m_srr1);
            chk("vect_busy", busy, 1);
            chk("vect_no_wr", msr_wr, 0);
            chk("vect_msr", msr_rd, m_msr);
            if (rst_at == 2) rst = 1'b1;
            tick();
            core_msr_wr = 1'b0;
            if (rst_at == 2) begin
                rst = 1'b0; m_msr = 0; m_srr0 = 0; m_srr1 = 0;
                #1;
                chk("rst_vect_srr0", srr0, 0);
                chk("rst_vect_srr1", srr1, 0);
            end
        end else if (kind == 4) begin
            new_msr = m_srr1 & 32'h0000_9001;
            chk("rfi_busy", busy, 1);
            chk("rfi_wr", msr_wr, 1);
            chk("rfi_wd", msr_wd, new_msr);
            tick();
            m_msr = new_msr;
            core_msr_wr = 1'b1; core_msr_wd = $urandom;
            #1;
            chk("ret_redir", redir_vld, 1);
            chk("ret_pc", redir_pc, m_srr0);
            chk("ret_msr", msr_rd, m_msr);
            chk("ret_no_wr", msr_wr, 0);
            tick();
            core_msr_wr = 1'b0;
        end else if (kind == 5) begin
            for (int i = 0; i < 4; i++) begin
                chk("stop_chk", checkstop, 1);
                chk("stop_busy", busy, 1);
                chk("stop_no_wr", msr_wr, 0);
                chk("stop_redir", redir_vld, 0);
                tick();
                core_msr_wr = 1'b1; core_msr_wd = $urandom;
                #1;
            end
            core_msr_wr = 1'b0;
            return;
        end
        #1;
        chk("back_idle_busy", busy, 0);
        chk("back_idle_redir", redir_vld, 0);
    endtask

    initial begin
        mchk = 0; ext_irq = 0; sc_req = 0; rfi_req = 0;
        pc_cur = 0; core_msr_wr = 0; core_msr_wd = 0;
        do_reset();

        // system call with EE=1, LE=1
        do_event(0, 0, 0, 0, 32'h0, 1, 32'h0000_8001, 0);
        do_event(0, 0, 1, 0, 32'h100, 0, 0, 0);

        // pending interrupt with EE=0, then enable via mtmsr
        do_event(0, 1, 0, 0, 32'h140, 0, 0, 0);
        do_event(0, 1, 0, 0, 32'h144, 1, 32'h0000_8000, 0);
        do_event(0, 1, 0, 0, 32'h148, 0, 0, 0);

        // rfi restoring EE with ext_irq held: interrupt taken right after return
        do_event(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0);
        do_event(0, 0, 1, 0, 32'h2000, 0, 0, 0);
        do_event(0, 1, 0, 1, 32'h1FF0, 0, 0, 0);
        do_event(0, 1, 0, 0, 32'h2000, 0, 0, 0);

        // interrupt beats rfi in the same cycle
        do_event(0, 0, 0, 0, 32'h0, 1, 32'h0000_8000, 0);
        do_event(0, 1, 0, 1, 32'h300, 0, 0, 0);

        // reset while in VECT, then while in SAVE
        do_event(0, 0, 1, 0, 32'h400, 0, 0, 2);
        do_event(0, 0, 1, 0, 32'h404, 0, 0, 1);

        // random traffic, machine check only while ME=1
        for (int n = 0; n < 200; n++) begin
            bit mc, ex, sc, rf, wr;
            mc = ($urandom_range(0, 9) == 0) && ((m_msr & 32'h1000) != 0);
            ex = ($urandom_range(0, 3) == 0);
            sc = ($urandom_range(0, 4) == 0);
            rf = ($urandom_range(0, 4) == 0);
            wr = ($urandom_range(0, 3) == 0);
            do_event(mc, ex, sc, rf, $urandom, wr, $urandom, 0);
        end

        // machine check with ME=1, then a second one with ME=0 checkstops
        do_event(0, 0, 0, 0, 32'h0, 1, 32'h0000_9000, 0);
        do_event(1, 0, 0, 0, 32'h600, 0, 0, 0);
        do_event(1, 0, 0, 0, 32'h700, 0, 0, 0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
